// File: rtl/e_stage_md_pkg.sv
// Shared control encodings and the instruction decoder for the MIPS execute stage
// with its multiply/divide unit.
package e_stage_md_pkg;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {ALUB_RT, ALUB_EXT, ALUB_SHAMT} alub_sel_e;
   typedef enum logic [1:0] {A3_NONE, A3_RT, A3_RD, A3_RA} grfa3_sel_e;
   typedef enum logic [0:0] {WD_NONE, WD_LINK} grfwd_sel_e;

   typedef enum logic [3:0] {
      MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO
   } md_op_e;

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

   typedef struct packed {
      alu_op_e    alu_op;
      alub_sel_e  alub_sel;
      grfa3_sel_e a3_sel;
      grfwd_sel_e wd_sel;
      md_op_e     md_op;
   } ctrl_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                          OP_LW = 6'h23, OP_SW = 6'h2b;

   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_MFHI = 6'h10, F_MTHI = 6'h11,
                          F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                          F_DIV = 6'h1a, F_DIVU = 6'h1b, F_ADDU = 6'h21, F_SUBU = 6'h23,
                          F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2a;

   function automatic ctrl_t cu_decode(input logic [31:0] ir);
      ctrl_t c;
      c = '{alu_op: ALU_ADD, alub_sel: ALUB_RT, a3_sel: A3_NONE, wd_sel: WD_NONE, md_op: MD_NONE};
      case (ir[31:26])
         OP_SPECIAL: begin
            case (ir[5:0])
               F_SLL:   begin c.alu_op = ALU_SLL; c.alub_sel = ALUB_SHAMT; c.a3_sel = A3_RD; end
               F_SRL:   begin c.alu_op = ALU_SRL; c.alub_sel = ALUB_SHAMT; c.a3_sel = A3_RD; end
               F_ADDU:  begin c.alu_op = ALU_ADD; c.a3_sel = A3_RD; end
               F_SUBU:  begin c.alu_op = ALU_SUB; c.a3_sel = A3_RD; end
               F_AND:   begin c.alu_op = ALU_AND; c.a3_sel = A3_RD; end
               F_OR:    begin c.alu_op = ALU_OR;  c.a3_sel = A3_RD; end
               F_SLT:   begin c.alu_op = ALU_SLT; c.a3_sel = A3_RD; end
               F_MFHI:  begin c.md_op = MD_MFHI; c.a3_sel = A3_RD; end
               F_MFLO:  begin c.md_op = MD_MFLO; c.a3_sel = A3_RD; end
               F_MTHI:  c.md_op = MD_MTHI;
               F_MTLO:  c.md_op = MD_MTLO;
               F_MULT:  c.md_op = MD_MULT;
               F_MULTU: c.md_op = MD_MULTU;
               F_DIV:   c.md_op = MD_DIV;
               F_DIVU:  c.md_op = MD_DIVU;
               default: c.md_op = MD_NONE;
            endcase
         end
         OP_JAL:   begin c.a3_sel = A3_RA; c.wd_sel = WD_LINK; end
         OP_BEQ:   c.alu_op = ALU_SUB;
         OP_ADDIU: begin c.alub_sel = ALUB_EXT; c.a3_sel = A3_RT; end
         OP_ORI:   begin c.alu_op = ALU_OR;  c.alub_sel = ALUB_EXT; c.a3_sel = A3_RT; end
         OP_LUI:   begin c.alu_op = ALU_LUI; c.alub_sel = ALUB_EXT; c.a3_sel = A3_RT; end
         OP_LW:    begin c.alub_sel = ALUB_EXT; c.a3_sel = A3_RT; end
         OP_SW:    c.alub_sel = ALUB_EXT;
         default:  c.md_op = MD_NONE;
      endcase
      return c;
   endfunction

   function automatic logic is_md_class(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/e_stage_md_if.sv
// D/E input bundle, forwarding sources and E/M output bundle of the execute stage.
interface e_stage_md_if #(
   parameter int DATA_W = 32,
   parameter int FWD_N  = 2
);
   logic                    Reg_Rst;
   logic                    We;
   logic [31:0]             IR_in;
   logic [DATA_W-1:0]       PC_in;
   logic [DATA_W-1:0]       RD1_in;
   logic [DATA_W-1:0]       RD2_in;
   logic [DATA_W-1:0]       EXT_in;
   logic [5*FWD_N-1:0]      fwd_a3;
   logic [DATA_W*FWD_N-1:0] fwd_wd;
   logic [FWD_N-1:0]        fwd_wr;
   logic [FWD_N-1:0]        fwd_rdy;
   logic [31:0]             IR_out;
   logic [DATA_W-1:0]       PC_out;
   logic [DATA_W-1:0]       Y_out;
   logic [DATA_W-1:0]       V2_out;
   logic [4:0]              E_RFA3_out;
   logic [DATA_W-1:0]       E_RFWD_out;
   logic                    E_RFWr_out;
   logic                    E_Forward_Ready_out;
   logic                    md_busy;

   modport master (
      output Reg_Rst, We, IR_in, PC_in, RD1_in, RD2_in, EXT_in,
             fwd_a3, fwd_wd, fwd_wr, fwd_rdy,
      input  IR_out, PC_out, Y_out, V2_out, E_RFA3_out, E_RFWD_out,
             E_RFWr_out, E_Forward_Ready_out, md_busy
   );

   modport slave (
      input  Reg_Rst, We, IR_in, PC_in, RD1_in, RD2_in, EXT_in,
             fwd_a3, fwd_wd, fwd_wr, fwd_rdy,
      output IR_out, PC_out, Y_out, V2_out, E_RFA3_out, E_RFWD_out,
             E_RFWr_out, E_Forward_Ready_out, md_busy
   );
endinterface

// File: rtl/e_stage_md_muldiv.sv
// Multi-cycle multiply/divide unit: latches operands at start, counts down, then
// commits the result to HI/LO. Owns HI/LO, so mthi/mtlo land here too.
module e_stage_md_muldiv
   import e_stage_md_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  md_op_e            op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              counting
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   md_op_e            op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

   logic [2*DATA_W-1:0] sprod_s, uprod_s;
   logic [DATA_W-1:0]   squot_s, srem_s, uquot_s, urem_s;
   logic                div0_s;

   // Low 2*DATA_W bits of the sign-extended product equal the signed product.
   assign sprod_s = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
   assign uprod_s = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
   assign squot_s = $unsigned($signed(a_q) / $signed(b_q));
   assign srem_s  = $unsigned($signed(a_q) % $signed(b_q));
   assign uquot_s = a_q / b_q;
   assign urem_s  = a_q % b_q;
   assign div0_s  = (b_q == {DATA_W{1'b0}});

   // Next-state for the countdown, operand latches and HI/LO.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                              : CNT_W'(DIV_CYCLES);
               op_d    = op;
               a_d     = a;
               b_d     = b;
            end else begin
               hi_d = hi_we ? wdata : hi_q;
               lo_d = lo_we ? wdata : lo_q;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1'b1);
            if (cnt_q == CNT_W'(1'b1)) begin
               state_d = MD_IDLE;
               case (op_q)
                  MD_MULT:  {hi_d, lo_d} = sprod_s;
                  MD_MULTU: {hi_d, lo_d} = uprod_s;
                  MD_DIV:   begin hi_d = div0_s ? hi_q : srem_s; lo_d = div0_s ? lo_q : squot_s; end
                  MD_DIVU:  begin hi_d = div0_s ? hi_q : urem_s; lo_d = div0_s ? lo_q : uquot_s; end
                  default:  begin hi_d = hi_q; lo_d = lo_q; end
               endcase
            end else begin
               state_d = MD_BUSY;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // Unit registers; reset aborts any running op and clears HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign counting = (state_q == MD_BUSY);
endmodule

// File: rtl/e_stage_md.sv
// MIPS execute stage: E pipeline register, N-source operand forwarding, ALU,
// mult/div issue and the E forwarding tuple fed back to D.
module e_stage_md
   import e_stage_md_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int FWD_N       = 2,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic         Clk,
   input logic         Rst,
   e_stage_md_if.slave bus
);
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, ext_q, ext_d;
   logic              issued_q, issued_d;

   ctrl_t             ctrl_s;
   logic [4:0]        rs_s, rt_s, rd_s, shamt_s, a3_s;
   logic [DATA_W-1:0] rs_fwd_s, rt_fwd_s, alu_b_s, alu_y_s, hi_s, lo_s;
   logic              counting_s, start_s;

   logic [FWD_N-1:0]  hit_rs_s, hit_rt_s;
   logic [DATA_W-1:0] fwd_wd_s [FWD_N];

   // E register next-state; a load or flush re-arms mult/div issue.
   always_comb begin
      if (bus.Reg_Rst) begin
         ir_d = '0; pc_d = '0; rd1_d = '0; rd2_d = '0; ext_d = '0;
         issued_d = 1'b0;
      end else if (bus.We) begin
         ir_d = bus.IR_in; pc_d = bus.PC_in; rd1_d = bus.RD1_in;
         rd2_d = bus.RD2_in; ext_d = bus.EXT_in;
         issued_d = 1'b0;
      end else begin
         ir_d = ir_q; pc_d = pc_q; rd1_d = rd1_q; rd2_d = rd2_q; ext_d = ext_q;
         issued_d = issued_q | start_s;
      end
   end

   // E pipeline register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ir_q <= '0; pc_q <= '0; rd1_q <= '0; rd2_q <= '0; ext_q <= '0;
         issued_q <= 1'b0;
      end else begin
         ir_q <= ir_d; pc_q <= pc_d; rd1_q <= rd1_d; rd2_q <= rd2_d; ext_q <= ext_d;
         issued_q <= issued_d;
      end
   end

   assign ctrl_s  = cu_decode(ir_q);
   assign rs_s    = ir_q[25:21];
   assign rt_s    = ir_q[20:16];
   assign rd_s    = ir_q[15:11];
   assign shamt_s = ir_q[10:6];

   for (genvar i = 0; i < FWD_N; i++) begin : g_fwd
      assign fwd_wd_s[i] = bus.fwd_wd[i*DATA_W +: DATA_W];
      assign hit_rs_s[i] = (bus.fwd_a3[i*5 +: 5] == rs_s) && bus.fwd_wr[i] && bus.fwd_rdy[i];
      assign hit_rt_s[i] = (bus.fwd_a3[i*5 +: 5] == rt_s) && bus.fwd_wr[i] && bus.fwd_rdy[i];
   end

   // Operand select: walk from farthest source down so the nearest ready hit wins.
   always_comb begin
      rs_fwd_s = rd1_q;
      rt_fwd_s = rd2_q;
      for (int i = FWD_N - 1; i >= 0; i--) begin
         rs_fwd_s = hit_rs_s[i] ? fwd_wd_s[i] : rs_fwd_s;
         rt_fwd_s = hit_rt_s[i] ? fwd_wd_s[i] : rt_fwd_s;
      end
      rs_fwd_s = (rs_s == 5'd0) ? '0 : rs_fwd_s;
      rt_fwd_s = (rt_s == 5'd0) ? '0 : rt_fwd_s;
   end

   // ALU B operand and result.
   always_comb begin
      case (ctrl_s.alub_sel)
         ALUB_EXT:   alu_b_s = ext_q;
         ALUB_SHAMT: alu_b_s = {{(DATA_W-5){1'b0}}, shamt_s};
         default:    alu_b_s = rt_fwd_s;
      endcase
      case (ctrl_s.alu_op)
         ALU_SUB: alu_y_s = rs_fwd_s - alu_b_s;
         ALU_AND: alu_y_s = rs_fwd_s & alu_b_s;
         ALU_OR:  alu_y_s = rs_fwd_s | alu_b_s;
         ALU_SLT: alu_y_s = {{(DATA_W-1){1'b0}}, ($signed(rs_fwd_s) < $signed(alu_b_s))};
         ALU_SLL: alu_y_s = rt_fwd_s << alu_b_s[4:0];
         ALU_SRL: alu_y_s = rt_fwd_s >> alu_b_s[4:0];
         ALU_LUI: alu_y_s = alu_b_s << 5'd16;
         default: alu_y_s = rs_fwd_s + alu_b_s;
      endcase
   end

   // Destination register for the forwarding tuple.
   always_comb begin
      case (ctrl_s.a3_sel)
         A3_RT:   a3_s = rt_s;
         A3_RD:   a3_s = rd_s;
         A3_RA:   a3_s = 5'd31;
         default: a3_s = 5'd0;
      endcase
   end

   // A held md op issues once; busy covers the start cycle plus the countdown.
   assign start_s = is_md_class(ctrl_s.md_op) && !counting_s && !issued_q;

   e_stage_md_muldiv #(
      .DATA_W      (DATA_W),
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_muldiv (
      .clk      (Clk),
      .rst      (Rst),
      .start    (start_s),
      .op       (ctrl_s.md_op),
      .a        (rs_fwd_s),
      .b        (rt_fwd_s),
      .hi_we    (ctrl_s.md_op == MD_MTHI),
      .lo_we    (ctrl_s.md_op == MD_MTLO),
      .wdata    (rs_fwd_s),
      .hi       (hi_s),
      .lo       (lo_s),
      .counting (counting_s)
   );

   assign bus.IR_out              = ir_q;
   assign bus.PC_out              = pc_q;
   assign bus.V2_out              = rt_fwd_s;
   assign bus.Y_out               = (ctrl_s.md_op == MD_MFHI) ? hi_s :
                                    (ctrl_s.md_op == MD_MFLO) ? lo_s : alu_y_s;
   assign bus.E_RFA3_out          = a3_s;
   assign bus.E_RFWr_out          = (a3_s != 5'd0);
   assign bus.E_RFWD_out          = (ctrl_s.wd_sel == WD_LINK) ? (pc_q + DATA_W'(32'd8)) : '0;
   assign bus.E_Forward_Ready_out = (ctrl_s.wd_sel == WD_LINK);
   assign bus.md_busy             = start_s | counting_s;
endmodule

// File: tb/tb_e_stage_md.sv
// Directed bench for e_stage_md: forwarding, ALU, link tuple, mult/div timing and results.
module tb_e_stage_md;
   localparam int DW = 32;
   localparam int FN = 2;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   total = 0;
   int   passed = 0;

   e_stage_md_if #(.DATA_W(DW), .FWD_N(FN)) bus ();

   e_stage_md #(.DATA_W(DW), .FWD_N(FN), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic load(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] ext);
      bus.IR_in  = ir;
      bus.PC_in  = pc;
      bus.RD1_in = rd1;
      bus.RD2_in = rd2;
      bus.EXT_in = ext;
      @(posedge Clk);
      #1;
   endtask

   // Issue an md op, then feed n nops; busy must span the start cycle plus n more.
   task automatic run_md(input string tag, input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b, input int n);
      int nb;
      load(ir, 32'h0, a, b, 32'h0);
      chk({tag, " start busy"}, {31'd0, bus.md_busy}, 32'd1);
      nb = 0;
      for (int i = 0; i < n; i++) begin
         load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
         nb += int'(bus.md_busy);
      end
      chk({tag, " busy cycles"}, 32'(nb), 32'(n));
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      load(rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h10), 32'h0, 32'h0, 32'h0, 32'h0);
      chk({tag, " idle"}, {31'd0, bus.md_busy}, 32'd0);
      chk({tag, " HI"}, bus.Y_out, exp_hi);
      load(rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h12), 32'h0, 32'h0, 32'h0, 32'h0);
      chk({tag, " LO"}, bus.Y_out, exp_lo);
   endtask

   logic [31:0] addu_ir, mult_ir, multu_ir, div_ir;

   initial begin
      addu_ir  = rtype(5'd8, 5'd9, 5'd10, 5'd0, 6'h21);
      mult_ir  = rtype(5'd8, 5'd9, 5'd0, 5'd0, 6'h18);
      multu_ir = rtype(5'd8, 5'd9, 5'd0, 5'd0, 6'h19);
      div_ir   = rtype(5'd8, 5'd9, 5'd0, 5'd0, 6'h1a);
      bus.Reg_Rst = 1'b0;
      bus.We      = 1'b1;
      bus.fwd_a3  = '0;
      bus.fwd_wd  = '0;
      bus.fwd_wr  = '0;
      bus.fwd_rdy = '0;

      // Reset with live inputs: everything must read as a nop.
      Rst = 1'b1;
      load(addu_ir, 32'h3000, 32'd5, 32'd6, 32'd0);
      load(addu_ir, 32'h3000, 32'd5, 32'd6, 32'd0);
      chk("rst IR", bus.IR_out, 32'h0);
      chk("rst PC", bus.PC_out, 32'h0);
      chk("rst Y", bus.Y_out, 32'h0);
      chk("rst V2", bus.V2_out, 32'h0);
      chk("rst A3", {27'd0, bus.E_RFA3_out}, 32'h0);
      chk("rst Wr", {31'd0, bus.E_RFWr_out}, 32'h0);
      chk("rst busy", {31'd0, bus.md_busy}, 32'h0);
      Rst = 1'b0;

      // Forwarding: src0 and src1 both target $t0.
      bus.fwd_a3  = {5'd8, 5'd8};
      bus.fwd_wd  = {32'd9, 32'd7};
      bus.fwd_wr  = 2'b11;
      bus.fwd_rdy = 2'b11;
      load(addu_ir, 32'h3004, 32'd1, 32'd3, 32'd0);
      chk("fwd src0", bus.Y_out, 32'd10);
      chk("fwd V2", bus.V2_out, 32'd3);
      chk("addu A3", {27'd0, bus.E_RFA3_out}, 32'd10);
      chk("addu Wr", {31'd0, bus.E_RFWr_out}, 32'd1);
      chk("addu Rdy", {31'd0, bus.E_Forward_Ready_out}, 32'd0);
      bus.fwd_rdy = 2'b10;
      #1;
      chk("fwd src1", bus.Y_out, 32'd12);
      bus.fwd_rdy = 2'b00;
      #1;
      chk("fwd none", bus.Y_out, 32'd4);
      bus.fwd_a3  = {5'd9, 5'd0};
      bus.fwd_rdy = 2'b11;
      #1;
      chk("fwd rt", bus.V2_out, 32'd9);
      chk("fwd zero reg ignored", bus.Y_out, 32'd10);
      bus.fwd_wr  = 2'b00;
      bus.fwd_rdy = 2'b00;

      // ALU with immediate and shamt.
      load(itype(6'h0d, 5'd8, 5'd9, 16'h00F0), 32'h0, 32'h0F00, 32'd0, 32'h000000F0);
      chk("ori Y", bus.Y_out, 32'h0FF0);
      chk("ori A3", {27'd0, bus.E_RFA3_out}, 32'd9);
      load(rtype(5'd0, 5'd9, 5'd10, 5'd4, 6'h00), 32'h0, 32'd0, 32'd3, 32'd0);
      chk("sll Y", bus.Y_out, 32'h30);

      // Link tuple.
      load({6'h03, 26'h0000C00}, 32'h3000, 32'd0, 32'd0, 32'd0);
      chk("jal A3", {27'd0, bus.E_RFA3_out}, 32'd31);
      chk("jal WD", bus.E_RFWD_out, 32'h3008);
      chk("jal Rdy", {31'd0, bus.E_Forward_Ready_out}, 32'd1);
      chk("jal PC", bus.PC_out, 32'h3000);

      // Mult/div results and exact latency (mfhi at t+N+1).
      run_md("mult", mult_ir, 32'hFFFFFFFF, 32'd2, 5);
      read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_md("multu", multu_ir, 32'hFFFFFFFF, 32'd2, 5);
      read_hilo("multu", 32'h1, 32'hFFFFFFFE);
      run_md("div", div_ir, 32'hFFFFFFF9, 32'd2, 10);
      read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_md("div0", div_ir, 32'd5, 32'd0, 10);
      read_hilo("div0", 32'hFFFFFFFF, 32'hFFFFFFFD);

      // Flush right after start: op still completes.
      load(mult_ir, 32'h0, 32'd3, 32'd4, 32'd0);
      bus.Reg_Rst = 1'b1;
      load(mult_ir, 32'h0, 32'd3, 32'd4, 32'd0);
      bus.Reg_Rst = 1'b0;
      chk("flush IR", bus.IR_out, 32'h0);
      chk("flush busy", {31'd0, bus.md_busy}, 32'd1);
      for (int i = 0; i < 4; i++) load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      read_hilo("flush", 32'h0, 32'd12);

      // Reset mid-op aborts and clears HI/LO.
      load(mult_ir, 32'h0, 32'd6, 32'd7, 32'd0);
      load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      Rst = 1'b1;
      load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      Rst = 1'b0;
      chk("rst midop busy", {31'd0, bus.md_busy}, 32'd0);
      for (int i = 0; i < 6; i++) load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      read_hilo("rst midop", 32'h0, 32'h0);

      // Held mult (We=0) past its completion issues only once.
      load(mult_ir, 32'h0, 32'd2, 32'd3, 32'd0);
      bus.We = 1'b0;
      begin
         int nb;
         nb = 0;
         for (int i = 0; i < 7; i++) begin
            load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
            nb += int'(bus.md_busy);
         end
         chk("hold busy cycles", 32'(nb), 32'd5);
      end
      chk("hold IR", bus.IR_out, mult_ir);
      bus.We = 1'b1;
      read_hilo("hold", 32'h0, 32'd6);

      // mthi/mtlo when idle.
      load(rtype(5'd8, 5'd0, 5'd0, 5'd0, 6'h11), 32'h0, 32'd5, 32'd0, 32'd0);
      load(rtype(5'd8, 5'd0, 5'd0, 5'd0, 6'h13), 32'h0, 32'd9, 32'd0, 32'd0);
      read_hilo("mthi/mtlo", 32'd5, 32'd9);

      // Final reset clears the link tuple.
      load({6'h03, 26'h0000C00}, 32'h3000, 32'd0, 32'd0, 32'd0);
      Rst = 1'b1;
      load({6'h03, 26'h0000C00}, 32'h3000, 32'd0, 32'd0, 32'd0);
      chk("rst2 WD", bus.E_RFWD_out, 32'h0);
      chk("rst2 A3", {27'd0, bus.E_RFA3_out}, 32'h0);
      chk("rst2 Rdy", {31'd0, bus.E_Forward_Ready_out}, 32'h0);
      chk("rst2 PC", bus.PC_out, 32'h0);
      Rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
